// File: rtl/mem_ram_pkg.sv
// rtl/mem_ram_pkg.sv - shared RAM geometry and burst sequencer state encoding
package mem_ram_pkg;

   localparam int MEM_ADDR_W = 6;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } burst_state_t;

endpackage

// File: rtl/mem_ram_burst_ctrl.sv
// rtl/mem_ram_burst_ctrl.sv - single-command burst sequencer in front of the 64x8 sync RAM
module mem_ram_burst_ctrl
   import mem_ram_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              mem_read_rq,
   output logic              mem_write_rq,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   burst_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              wr_beat;
   logic              rd_beat;
   logic              beat;
   logic              last_beat;

   always_comb begin
      wr_beat   = (state_q == WRITE) && wr_valid;
      // A held output byte blocks the next read until it is consumed.
      rd_beat   = (state_q == READ) && (!rd_valid_q || rd_ready);
      beat      = wr_beat || rd_beat;
      last_beat = beat && (cnt_q == '0);

      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               state_d = cmd_write ? WRITE : READ;
            end
         end
         WRITE, READ: begin
            if (beat) begin
               addr_d = addr_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The output register is serviced in every state so a byte left
      // over from the previous burst drains while IDLE or the next burst runs.
      if (rd_beat) begin
         rd_data_d  = mem_rdata;
         rd_valid_d = 1'b1;
      end else if (rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign wr_ready     = (state_q == WRITE);
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign mem_write_rq = wr_beat;
   assign mem_read_rq  = rd_beat;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wr_data;

endmodule

// File: tb/tb_mem_ram_burst_ctrl.sv
// tb/tb_mem_ram_burst_ctrl.sv - vector table plus scoreboard bench for mem_ram_burst_ctrl
module tb_mem_ram_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [5:0] cmd_addr = '0;
   logic [5:0] cmd_len = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic       rd_ready = 1'b1;
   logic [7:0] rd_data;
   logic       busy;
   logic       mem_read_rq;
   logic       mem_write_rq;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   always #5 clk = ~clk;

   mem_ram_burst_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .mem_read_rq(mem_read_rq), .mem_write_rq(mem_write_rq),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural 64x8 RAM: sync write, combinational read while requested, cleared by reset.
   logic [7:0] ram [64];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int j = 0; j < 64; j++) ram[j] <= 8'h00;
      end else if (mem_write_rq) begin
         ram[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_read_rq ? ram[mem_addr] : 8'h00;

   int n_vec = 0;
   int n_err = 0;
   int n_wr_rq = 0;
   int n_rd_rq = 0;

   logic [7:0]  shadow [64];
   logic [13:0] wr_q [$];
   logic [5:0]  ra_q [$];
   logic [7:0]  rd_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples mid-cycle and pops scoreboard entries as the DUT produces them.
   logic       prev_rd_rq = 1'b0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_rd_data = '0;
   logic [13:0] we;
   always @(negedge clk) begin
      if (!rst) begin
         prev_rd_rq = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         chk("rq_exclusive", 32'(mem_write_rq && mem_read_rq), 32'd0);
         if (mem_write_rq) begin
            n_wr_rq++;
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               we = wr_q.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(we[13:8]));
               chk("wr_data", 32'(mem_wdata), 32'(we[7:0]));
            end
         end
         if (mem_read_rq) begin
            n_rd_rq++;
            chk("rd_rq_expected", 32'(ra_q.size() != 0), 32'd1);
            if (ra_q.size() != 0) chk("rd_addr", 32'(mem_addr), 32'(ra_q.pop_front()));
         end
         if (prev_rd_rq) chk("rd_valid_latency", 32'(rd_valid), 32'd1);
         if (prev_hold) begin
            chk("rd_hold_valid", 32'(rd_valid), 32'd1);
            chk("rd_hold_data", 32'(rd_data), 32'(prev_rd_data));
         end
         if (rd_valid && rd_ready) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
         end
         prev_rd_rq   = mem_read_rq;
         prev_hold    = rd_valid && !rd_ready;
         prev_rd_data = rd_data;
      end
   end

   typedef struct {
      logic       write;
      logic [5:0] addr;
      logic [5:0] len;
      logic [7:0] base;
      logic       toggle;
      int         stall;
      int         exp_busy;
      int         exp_rq;
   } vec_t;

   vec_t vecs [11];

   task automatic push_expect(input logic wr, input logic [5:0] addr, input logic [5:0] len,
                              input logic [7:0] base);
      logic [5:0] a;
      for (int j = 0; j <= int'(len); j++) begin
         a = addr + 6'(j);
         if (wr) begin
            shadow[a] = base + 8'(j);
            wr_q.push_back({a, shadow[a]});
         end else begin
            ra_q.push_back(a);
            rd_q.push_back(shadow[a]);
         end
      end
   endtask

   task automatic run_cmd(input vec_t v, input int idx);
      int  i;
      int  busy_n;
      int  rq0;
      bit  done;
      push_expect(v.write, v.addr, v.len, v.base);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
      rq0 = v.write ? n_wr_rq : n_rd_rq;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      i = 0; busy_n = 0; done = 0;
      for (int k = 0; k < 300; k++) begin
         wr_valid = v.write && (!v.toggle || (k % 2 == 0));
         wr_data  = v.base + 8'(i);
         rd_ready = !(k >= 1 && k <= v.stall);
         @(negedge clk);
         if (!busy) begin
            done = 1;
            break;
         end
         busy_n++;
         if (wr_valid && wr_ready) i++;
         @(posedge clk); #1;
      end
      chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(v.exp_busy));
      chk($sformatf("v%0d_rq_count", idx),
          32'((v.write ? n_wr_rq : n_rd_rq) - rq0), 32'(v.exp_rq));
      chk($sformatf("v%0d_cmd_ready_after", idx), 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 6'd40, 6'd63, 8'h80, 1'b0, 0, 64, 64};
      vecs[1]  = '{1'b0, 6'd40, 6'd63, 8'h00, 1'b0, 0, 64, 64};
      vecs[2]  = '{1'b1, 6'd5,  6'd3,  8'hA1, 1'b0, 0, 4, 4};
      vecs[3]  = '{1'b0, 6'd5,  6'd3,  8'h00, 1'b0, 0, 4, 4};
      vecs[4]  = '{1'b1, 6'd62, 6'd3,  8'h10, 1'b0, 0, 4, 4};
      vecs[5]  = '{1'b0, 6'd62, 6'd3,  8'h00, 1'b0, 0, 4, 4};
      vecs[6]  = '{1'b0, 6'd5,  6'd2,  8'h00, 1'b0, 3, 6, 3};
      vecs[7]  = '{1'b1, 6'd20, 6'd3,  8'h30, 1'b1, 0, 7, 4};
      vecs[8]  = '{1'b0, 6'd20, 6'd3,  8'h00, 1'b0, 0, 4, 4};
      vecs[9]  = '{1'b1, 6'd0,  6'd0,  8'hEE, 1'b0, 0, 1, 1};
      vecs[10] = '{1'b0, 6'd63, 6'd1,  8'h00, 1'b0, 0, 2, 2};
      for (int j = 0; j < 64; j++) shadow[j] = 8'h00;

      wr_data = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_mem_rqs", 32'({mem_read_rq, mem_write_rq}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'h5A);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int v = 0; v < 11; v++) run_cmd(vecs[v], v);

      // New command accepted while the previous burst's byte is still held.
      rd_ready = 1'b0;
      push_expect(1'b0, 6'd5, 6'd0, 8'h00);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd5; cmd_len = 6'd0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      push_expect(1'b0, 6'd6, 6'd0, 8'h00);
      cmd_valid = 1'b1; cmd_addr = 6'd6;
      @(negedge clk);
      chk("held_before_cmd", 32'(rd_valid), 32'd1);
      chk("held_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("held_no_rq", 32'(mem_read_rq), 32'd0);
         chk("held_busy", 32'(busy), 32'd1);
         chk("held_data", 32'(rd_data), 32'(shadow[5]));
         @(posedge clk); #1;
      end
      rd_ready = 1'b1;
      @(negedge clk);
      chk("held_release_rq", 32'(mem_read_rq), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("held_drained", 32'(rd_valid), 32'd0);

      // Reset during beat 2 of a 4-beat write.
      push_expect(1'b1, 6'd0, 6'd0, 8'h55);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h55;
      @(posedge clk); #1;
      wr_data = 8'h56;
      #1;
      chk("pre_reset_write_rq", 32'(mem_write_rq), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_wr_ready", 32'(wr_ready), 32'd0);
      chk("arst_write_rq", 32'(mem_write_rq), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_rd_valid", 32'(rd_valid), 32'd0);
      wr_valid = 1'b0;
      wr_q.delete(); ra_q.delete(); rd_q.delete();
      for (int j = 0; j < 64; j++) shadow[j] = 8'h00;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      run_cmd('{1'b0, 6'd0, 6'd3, 8'h00, 1'b0, 0, 4, 4}, 99);

      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
      chk("ra_q_empty", 32'(ra_q.size()), 32'd0);
      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_ram_burst_ctrl.md
# mem_ram_burst_ctrl

- Burst sequencer directly upstream of the 64x8 synchronous RAM (`mem_ram_sync`).
- Accepts one read or write burst command at a time over a valid/ready handshake.
- Walks the address range beat by beat, wrapping at 63 back to 0. Drives the RAM's `read_rq`/`write_rq`/`rw_address`/`write_data` pins.
- Moves payload bytes over separate write-in and read-out streams, at one beat per clock.

## Interface
Parameters:
- `ADDR_W`, 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8: data byte width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low. Shared with the RAM.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in ADDR_W: beat count minus 1, so the range is 1..64 beats.
- `wr_valid` in 1: write byte offered.
- `wr_ready` out 1: write byte accepted.
- `wr_data` in DATA_W: write byte.
- `rd_valid` out 1: read byte available.
- `rd_ready` in 1: downstream accepts the read byte.
- `rd_data` out DATA_W: read byte.
- `busy` out 1: state is not IDLE.
- `mem_read_rq` out 1: to RAM `read_rq`.
- `mem_write_rq` out 1: to RAM `write_rq`.
- `mem_addr` out ADDR_W: to RAM `rw_address`.
- `mem_wdata` out DATA_W: to RAM `write_data`.
- `mem_rdata` in DATA_W: from RAM `read_data`. The RAM presents this combinationally while `mem_read_rq` is high.

## Operation
States: IDLE, WRITE, READ.

**IDLE**
- `cmd_ready`=1.
- On `cmd_valid`:
  - Load `addr_q`←`cmd_addr` and `cnt_q`←`cmd_len`.
  - Go to WRITE if `cmd_write`, otherwise READ.

**WRITE**
- `wr_ready`=1.
- Write beat = `wr_valid`. On a write beat:
  - `mem_write_rq`=1 and `mem_wdata`=`wr_data` (combinational).
  - `addr_q`←`addr_q`+1 (mod 64).
  - `cnt_q`←`cnt_q`−1.
- Beat taken with `cnt_q`==0 → IDLE.
- With no `wr_valid`, no request is issued and state holds.

**READ**
- Read beat = `!rd_valid || rd_ready`. On a read beat:
  - `mem_read_rq`=1.
  - `rd_data`←`mem_rdata`, `rd_valid`←1.
  - `addr_q` and `cnt_q` advance as in WRITE.
- Beat taken with `cnt_q`==0 → IDLE.
- `rd_valid` clears when `rd_ready` is high and no new beat is captured.

**Rules in all states**
- `mem_addr`=`addr_q` at all times.
- `mem_read_rq` and `mem_write_rq` are never high together.
- Address arithmetic is ADDR_W-bit unsigned with silent wrap: a start at 62 with `cmd_len`=3 touches 62, 63, 0, 1.
- `cnt_q` is ADDR_W bits and never underflows; the 0 test happens before the decrement.
- A command arriving while `rd_valid` is still held from the previous burst is accepted. The held byte must not be overwritten until it is consumed.
- Reset, including mid-burst:
  - State→IDLE; `addr_q`, `cnt_q`, `rd_data` = 0; `rd_valid`=0.
  - All `mem_*` requests go low immediately (async).
  - The partial burst is discarded with no completion signalled. RAM contents are cleared by the same reset.

## Timing
- Reset values: `cmd_ready`=1; `busy`, `wr_ready`, `rd_valid`, `mem_read_rq`, `mem_write_rq` = 0; `rd_data`=0, `mem_addr`=0, `mem_wdata`=`wr_data`.
- Command accept to first beat opportunity: 1 cycle.
- Write: the byte is stored at the clock edge that ends its beat cycle. A read burst issued right after completion sees the new data.
- Read: `rd_valid`/`rd_data` rise 1 cycle after the beat's `mem_read_rq` cycle.
- Throughput is 1 beat/cycle when streams are never stalled. An N-beat burst occupies N cycles in WRITE/READ.
- Back-to-back commands: IDLE lasts at least 1 cycle between bursts.

## Structure
- Package `mem_ram_pkg` holds:
  - `MEM_ADDR_W`=6 and `MEM_DATA_W`=8, shared with the RAM.
  - The state enum `burst_state_t` {IDLE, WRITE, READ}.
- Single module with no sub-module. Registers: state, `addr_q`, `cnt_q`, `rd_data`/`rd_valid`.

## Test plan
1. Write burst addr=5, len=3, bytes A1..A4 with `wr_valid` held → `mem_write_rq` high 4 consecutive cycles at addresses 5, 6, 7, 8; `cmd_ready` returns the next cycle.
2. Read burst addr=5, len=3 with `rd_ready`=1 → `rd_data` A1, A2, A3, A4 on 4 consecutive cycles, starting 1 cycle after the first `mem_read_rq`.
3. Wrap: write addr=62, len=3, data 10..13, then read addr=62, len=3 → addresses 62, 63, 0, 1 and data 10..13.
4. Backpressure: read len=2 with `rd_ready` low for 3 cycles after the first byte → only 1 `mem_read_rq` issued while stalled; `rd_data` holds; no byte lost or duplicated.
5. Reset asserted during beat 2 of a 4-beat write → outputs take reset values asynchronously; after release `cmd_ready`=1 and reading addr 0..3 returns 0.
6. Write with `wr_valid` toggling 1, 0, 1, 0 → `mem_write_rq` high only on valid cycles; the burst ends after exactly len+1 accepted bytes.
